// File: rtl/psum_acc_pkg.sv
// Shared types and sizing helpers for the bit-serial partial-sum accumulator.
package psum_acc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    function automatic int acc_width(input int psum_w, input int in_bits);
        return psum_w + in_bits;
    endfunction

    function automatic int cnt_width(input int in_bits);
        return $clog2(in_bits);
    endfunction

endpackage

// File: rtl/psum_acc_ctrl_add.sv
// Two-operand adder, sum truncated to WIDTH; SUS selects sign extension of the operands.
module psum_acc_ctrl_add #(
    parameter int WIDTH = 8,
    parameter int SUS   = 1
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH:0] a_x;
    logic [WIDTH:0] b_x;

    assign a_x   = {(SUS != 0) && a_i[WIDTH-1], a_i};
    assign b_x   = {(SUS != 0) && b_i[WIDTH-1], b_i};
    assign sum_o = WIDTH'(a_x + b_x);

endmodule

// File: rtl/psum_acc_ctrl.sv
// Bit-serial (MSB-first) shift-accumulate controller for one CIM column.
// Optional PSUM_ACC_RELU_EN: clamps a negative signed result to zero in DONE.
module psum_acc_ctrl
    import psum_acc_pkg::*;
#(
    parameter int PSUM_W  = 12,
    parameter int IN_BITS = 8,
    parameter int ACC_W   = acc_width(PSUM_W, IN_BITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sus,
    input  logic [PSUM_W-1:0] psum,
    input  logic              psum_valid,
    output logic              psum_ready,
    output logic [ACC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              busy
);

    localparam int CNT_W = cnt_width(IN_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(IN_BITS - 1);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sus_q, sus_d;

    logic               first;
    logic [ACC_W-1:0]   ext;
    logic [ACC_W-1:0]   add_a;
    logic [ACC_W-1:0]   add_b;
    logic [ACC_W-1:0]   add_sum;

    assign first = (cnt_q == '0);
    assign ext   = {{(ACC_W-PSUM_W){sus_q & psum[PSUM_W-1]}}, psum};
    // MSB beat carries negative weight when signed: acc = 0 - ext.
    assign add_a = first ? '0 : {acc_q[ACC_W-2:0], 1'b0};
    assign add_b = (first && sus_q) ? (~ext + ACC_W'(1)) : ext;

    psum_acc_ctrl_add #(
        .WIDTH (ACC_W),
        .SUS   (1)
    ) u_add (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sus_q   <= sus_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sus_d        = sus_q;
        psum_ready   = 1'b0;
        result_valid = 1'b0;
        busy         = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ACC;
                    sus_d   = sus;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACC: begin
                psum_ready = 1'b1;
                if (psum_valid) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PSUM_ACC_RELU_EN
    assign result = ((state_q == DONE) && sus_q && acc_q[ACC_W-1]) ? '0 : acc_q;
`else
    assign result = acc_q;
`endif

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed bench for psum_acc_ctrl with hand-computed expected results.
module tb_psum_acc_ctrl;

    localparam int PSUM_W  = 12;
    localparam int IN_BITS = 8;
    localparam int ACC_W   = 20;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              sus;
    logic [PSUM_W-1:0] psum;
    logic              psum_valid;
    logic              psum_ready;
    logic [ACC_W-1:0]  result;
    logic              result_valid;
    logic              result_ready;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    psum_acc_ctrl #(
        .PSUM_W  (PSUM_W),
        .IN_BITS (IN_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .sus          (sus),
        .psum         (psum),
        .psum_valid   (psum_valid),
        .psum_ready   (psum_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic do_start(input logic s);
        start = 1'b1;
        sus   = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic beat(input logic [PSUM_W-1:0] p);
        psum       = p;
        psum_valid = 1'b1;
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic wait_rv(input string tag);
        int n = 0;
        while (!result_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(result_valid), 32'd1);
    endtask

    task automatic take_result(input string tag);
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sus          = 1'b0;
        psum         = '0;
        psum_valid   = 1'b0;
        result_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(psum_ready), 32'd0);
        check("rst_rv", 32'(result_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Unsigned, all ones: 255; result_valid in the 9th cycle counting the first-beat cycle.
        do_start(1'b0);
        check("uns_busy", 32'(busy), 32'd1);
        check("uns_ready", 32'(psum_ready), 32'd1);
        for (int i = 0; i < IN_BITS; i++) begin
            check("uns_rv_early", 32'(result_valid), 32'd0);
            beat(12'd1);
        end
        check("uns_rv", 32'(result_valid), 32'd1);
        check("uns_result", 32'(result), 32'h000FF);
        take_result("uns_idle");

        // Signed, 5 on the MSB beat: -5*128 = -640.
        do_start(1'b1);
        beat(12'd5);
        for (int i = 1; i < IN_BITS; i++) beat(12'd0);
        wait_rv("smsb_rv");
`ifdef PSUM_ACC_RELU_EN
        check("smsb_result", 32'(result), 32'h00000);
`else
        check("smsb_result", 32'(result), 32'hFFD80);
`endif
        take_result("smsb_idle");

        // Signed extremes: 2048*128 - 2048*127 = 2048.
        do_start(1'b1);
        for (int i = 0; i < IN_BITS; i++) beat(12'h800);
        wait_rv("sext_rv");
        check("sext_result", 32'(result), 32'h00800);
        take_result("sext_idle");

        // Bubbles, stray starts and backpressure; beats 1..8 unsigned -> 502.
        do_start(1'b0);
        for (int i = 0; i < 4; i++) beat(12'(i + 1));
        psum  = 12'hABC;
        start = 1'b1;
        sus   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bub_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        check("bub_busy1", 32'(busy), 32'd1);
        for (int i = 4; i < IN_BITS; i++) beat(12'(i + 1));
        wait_rv("bp_rv");
        psum       = 12'hFFF;
        psum_valid = 1'b1;
        start      = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_result", 32'(result), 32'h001F6);
            check("bp_ready", 32'(psum_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_rv_hold", 32'(result_valid), 32'd1);
            @(negedge clk);
        end
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("bp_hs_start_ignored", 32'(busy), 32'd0);
        start      = 1'b0;
        psum_valid = 1'b0;
        @(negedge clk);
        check("bp_still_idle", 32'(busy), 32'd0);
        check("bp_rv_low", 32'(result_valid), 32'd0);

        // Reset mid-pass discards everything asynchronously.
        do_start(1'b0);
        for (int i = 0; i < 3; i++) beat(12'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_ready", 32'(psum_ready), 32'd0);
        check("mrst_rv", 32'(result_valid), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_idle", 32'(busy), 32'd0);

        // Unsigned 3 on every beat: 3*255 = 765.
        do_start(1'b0);
        for (int i = 0; i < IN_BITS; i++) beat(12'd3);
        wait_rv("post_rv");
        check("post_result", 32'(result), 32'h002FD);
        take_result("post_idle");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
